// File: rtl/mdu_sched_if.sv
// mdu_sched_if: E/D-stage request and HI/LO result bundle for the MDU scheduler.
// master = pipeline side, slave = mdu_sched.
interface mdu_sched_if;
   logic        E_start;
   logic [3:0]  E_op;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        E_abort;
   logic        E_rd_hi;
   logic        D_md_use;
   logic        busy;
   logic        D_stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] E_HILO;

   modport master (
      output E_start, E_op, E_A, E_B, E_abort, E_rd_hi, D_md_use,
      input  busy, D_stall, HI, LO, E_HILO
   );

   modport slave (
      input  E_start, E_op, E_A, E_B, E_abort, E_rd_hi, D_md_use,
      output busy, D_stall, HI, LO, E_HILO
   );
endinterface

// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide scheduler and HI/LO owner. Models the unit's
// fixed latency with a countdown, commits HI/LO at completion and stalls D
// while HI/LO are unavailable.
// Optional feature: define MDU_MADD_EN to decode madd (7) and msub (8).
module mdu_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   mdu_sched_if.slave bus
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MSUB  = 4'd8
   } op_e;

   state_e             state;
   logic [CNT_W-1:0]   cnt;
   op_e                op_q;
   logic [31:0]        a_q;
   logic [31:0]        b_q;
   logic [31:0]        hi_q;
   logic [31:0]        lo_q;
   logic               busy_q;

   logic               start_mul;
   logic               start_div;
   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic [31:0]        quo_s;
   logic [31:0]        rem_s;
   logic [31:0]        quo_u;
   logic [31:0]        rem_u;
   logic [63:0]        res;
   logic               res_we;

   // Decode which E-stage ops occupy the unit (and therefore can stall D).
   always_comb begin
      start_mul = 1'b0;
      start_div = 1'b0;
      case (bus.E_op)
         OP_MULT, OP_MULTU: start_mul = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MSUB:  start_mul = 1'b1;
`endif
         OP_DIV, OP_DIVU:   start_div = 1'b1;
         default: ;
      endcase
   end

   // Arithmetic on the latched operands, consumed only at the commit edge.
   always_comb begin
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      quo_s  = $signed(a_q) / $signed(b_q);
      rem_s  = $signed(a_q) % $signed(b_q);
      quo_u  = a_q / b_q;
      rem_u  = a_q % b_q;
   end

   // Select the {HI,LO} result for the latched op; divide by zero writes nothing.
   always_comb begin
      res    = {hi_q, lo_q};
      res_we = 1'b0;
      case (op_q)
         OP_MULT: begin
            res    = prod_s;
            res_we = 1'b1;
         end
         OP_MULTU: begin
            res    = prod_u;
            res_we = 1'b1;
         end
         OP_DIV: begin
            res    = {rem_s, quo_s};
            res_we = (b_q != '0);
         end
         OP_DIVU: begin
            res    = {rem_u, quo_u};
            res_we = (b_q != '0);
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            res    = {hi_q, lo_q} + prod_s;
            res_we = 1'b1;
         end
         OP_MSUB: begin
            res    = {hi_q, lo_q} - prod_s;
            res_we = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Scheduler FSM: accept in IDLE, count down in RUN, commit on the last edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= OP_NONE;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.E_start && !bus.E_abort) begin
                  if (start_mul || start_div) begin
                     op_q   <= op_e'(bus.E_op);
                     a_q    <= bus.E_A;
                     b_q    <= bus.E_B;
                     cnt    <= start_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                     state  <= S_RUN;
                     busy_q <= 1'b1;
                  end else if (bus.E_op == OP_MTHI) begin
                     hi_q <= bus.E_A;
                  end else if (bus.E_op == OP_MTLO) begin
                     lo_q <= bus.E_A;
                  end
               end
            end
            S_RUN: begin
               if (bus.E_abort) begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state  <= S_IDLE;
                     busy_q <= 1'b0;
                     if (res_we) begin
                        hi_q <= res[63:32];
                        lo_q <= res[31:0];
                     end
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Outputs: stall covers the accept cycle (E_start term) and the whole RUN.
   assign bus.busy    = busy_q;
   assign bus.D_stall = bus.D_md_use & (busy_q | (bus.E_start & (start_mul | start_div)));
   assign bus.HI      = hi_q;
   assign bus.LO      = lo_q;
   assign bus.E_HILO  = bus.E_rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: scenario-driven bench for mdu_sched with an expected-result queue.
module tb_mdu_sched;

   logic clk;
   logic reset;
   mdu_sched_if bus();

   mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.E_start = 1'b1;
      bus.E_op    = op;
      bus.E_A     = a;
      bus.E_B     = b;
   endtask

   task automatic idle_inputs();
      bus.E_start = 1'b0;
      bus.E_op    = 4'd0;
      bus.E_A     = '0;
      bus.E_B     = '0;
   endtask

   // Called just after the accept edge; counts busy and stalled cycles until busy drops.
   task automatic wait_done(output int busy_cyc, output int stall_cyc, output bit timeout);
      busy_cyc  = 0;
      stall_cyc = 0;
      timeout   = 1'b0;
      idle_inputs();
      while (bus.busy === 1'b1) begin
         busy_cyc++;
         if (bus.D_stall === 1'b1) stall_cyc++;
         if (busy_cyc > 200) begin
            timeout = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", bus.busy);
      else n_pass++;
      n_checks++;
      if (bus.HI !== 32'h0 || bus.LO !== 32'h0)
         $display("FAIL reset_hilo got=%h_%h exp=0_0", bus.HI, bus.LO);
      else n_pass++;
      bus.D_md_use = 1'b1;
      #1;
      n_checks++;
      if (bus.D_stall !== 1'b0) $display("FAIL reset_stall_idle got=%0b exp=0", bus.D_stall);
      else n_pass++;
      issue(4'd1, 32'd0, 32'd0);
      #1;
      n_checks++;
      if (bus.D_stall !== 1'b1) $display("FAIL reset_stall_estart got=%0b exp=1", bus.D_stall);
      else n_pass++;
      idle_inputs();
      bus.D_md_use = 1'b0;
      #1;
   endtask

   task automatic test_mult();
      int bc, sc;
      bit to;
      logic acc_stall;
      exp_t e;
      bus.D_md_use = 1'b1;
      bus.E_rd_hi  = 1'b0;
      issue(4'd1, 32'hFFFFFFFE, 32'd3);
      sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA});
      #1;
      acc_stall = bus.D_stall;
      tick();
      wait_done(bc, sc, to);
      n_checks++;
      if (to) $display("FAIL mult_timeout busy never fell");
      else n_pass++;
      n_checks++;
      if (bc !== 5) $display("FAIL mult_busy_cycles got=%0d exp=5", bc);
      else n_pass++;
      n_checks++;
      if (sc + int'(acc_stall) !== 6) $display("FAIL mult_stall_cycles got=%0d exp=6", sc + int'(acc_stall));
      else n_pass++;
      n_checks++;
      if (bus.D_stall !== 1'b0) $display("FAIL mult_stall_release got=%0b exp=0", bus.D_stall);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL mult_result got=%h_%h exp=%h_%h", bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
      n_checks++;
      if (bus.E_HILO !== 32'hFFFFFFFA) $display("FAIL mult_ehilo_lo got=%h exp=fffffffa", bus.E_HILO);
      else n_pass++;
      bus.E_rd_hi = 1'b1;
      #1;
      n_checks++;
      if (bus.E_HILO !== 32'hFFFFFFFF) $display("FAIL mult_ehilo_hi got=%h exp=ffffffff", bus.E_HILO);
      else n_pass++;
      bus.E_rd_hi  = 1'b0;
      bus.D_md_use = 1'b0;
   endtask

   task automatic test_multu();
      int bc, sc;
      bit to;
      exp_t e;
      longint unsigned p;
      p = 64'(32'hFFFFFFFE) * 64'(32'd3);
      issue(4'd2, 32'hFFFFFFFE, 32'd3);
      sb.push_back('{hi: p[63:32], lo: p[31:0]});
      tick();
      wait_done(bc, sc, to);
      n_checks++;
      if (to || bc !== 5) $display("FAIL multu_busy_cycles got=%0d exp=5", bc);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL multu_result got=%h_%h exp=%h_%h", bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int bc, sc;
      bit to;
      exp_t e;
      issue(4'd4, 32'd17, 32'd5);
      sb.push_back('{hi: 32'd2, lo: 32'd3});
      sb.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
      tick();
      wait_done(bc, sc, to);
      n_checks++;
      if (to || bc !== 10) $display("FAIL divu_busy_cycles got=%0d exp=10", bc);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL divu_result got=%h_%h exp=%h_%h", bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
      // first IDLE cycle after commit: next start must be accepted here
      issue(4'd3, 32'hFFFFFFF9, 32'd2);
      tick();
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL b2b_accept busy got=%0b exp=1", bus.busy);
      else n_pass++;
      wait_done(bc, sc, to);
      n_checks++;
      if (to || bc !== 10) $display("FAIL div_busy_cycles got=%0d exp=10", bc);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL div_result got=%h_%h exp=%h_%h", bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
   endtask

   task automatic test_div_zero();
      int bc, sc;
      bit to;
      exp_t e;
      bus.D_md_use = 1'b1;
      issue(4'd5, 32'h11, 32'd0);
      #1;
      n_checks++;
      if (bus.D_stall !== 1'b0) $display("FAIL mthi_stall got=%0b exp=0", bus.D_stall);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.HI !== 32'h11 || bus.busy !== 1'b0)
         $display("FAIL mthi_write got=%h busy=%0b exp=00000011 busy=0", bus.HI, bus.busy);
      else n_pass++;
      issue(4'd6, 32'h22, 32'd0);
      tick();
      n_checks++;
      if (bus.LO !== 32'h22) $display("FAIL mtlo_write got=%h exp=00000022", bus.LO);
      else n_pass++;
      bus.D_md_use = 1'b0;
      issue(4'd3, 32'd5, 32'd0);
      sb.push_back('{hi: 32'h11, lo: 32'h22});
      tick();
      wait_done(bc, sc, to);
      n_checks++;
      if (to || bc !== 10) $display("FAIL divzero_busy_cycles got=%0d exp=10", bc);
      else n_pass++;
      e = sb.pop_front();
      n_checks++;
      if (bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL divzero_result got=%h_%h exp=%h_%h", bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
   endtask

   task automatic test_abort();
      bus.D_md_use = 1'b0;
      issue(4'd1, 32'd4, 32'd5);
      tick();
      idle_inputs();
      tick();
      tick();
      bus.E_abort = 1'b1;
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL abort_run3_busy got=%0b exp=1", bus.busy);
      else n_pass++;
      tick();
      bus.E_abort = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL abort_busy_fall got=%0b exp=0", bus.busy);
      else n_pass++;
      repeat (6) tick();
      n_checks++;
      if (bus.HI !== 32'h11 || bus.LO !== 32'h22)
         $display("FAIL abort_no_commit got=%h_%h exp=00000011_00000022", bus.HI, bus.LO);
      else n_pass++;
      bus.D_md_use = 1'b1;
      issue(4'd5, 32'hABCD, 32'd0);
      #1;
      n_checks++;
      if (bus.D_stall !== 1'b0) $display("FAIL abort_mthi_stall got=%0b exp=0", bus.D_stall);
      else n_pass++;
      tick();
      idle_inputs();
      n_checks++;
      if (bus.HI !== 32'hABCD) $display("FAIL abort_mthi_hi got=%h exp=0000abcd", bus.HI);
      else n_pass++;
      bus.D_md_use = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      issue(4'd3, 32'd100, 32'd7);
      tick();
      idle_inputs();
      tick();
      bus.D_md_use = 1'b1;
      #2;
      n_checks++;
      if (bus.busy !== 1'b1) $display("FAIL rstrun_precond busy got=%0b exp=1", bus.busy);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.D_stall !== 1'b0)
         $display("FAIL rstrun_async busy=%0b stall=%0b exp=0,0", bus.busy, bus.D_stall);
      else n_pass++;
      n_checks++;
      if (bus.HI !== 32'h0 || bus.LO !== 32'h0)
         $display("FAIL rstrun_hilo got=%h_%h exp=0_0", bus.HI, bus.LO);
      else n_pass++;
      #3;
      reset = 1'b1;
      bus.D_md_use = 1'b0;
      repeat (12) tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.HI !== 32'h0 || bus.LO !== 32'h0)
         $display("FAIL rstrun_no_commit busy=%0b hilo=%h_%h exp=0,0_0", bus.busy, bus.HI, bus.LO);
      else n_pass++;
   endtask

   task automatic test_madd();
      int bc, sc;
      bit to;
      logic acc_stall;
      exp_t e;
      issue(4'd5, 32'h0, 32'd0);
      tick();
      issue(4'd6, 32'hFFFFFFFF, 32'd0);
      tick();
      bus.D_md_use = 1'b1;
      issue(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      sb.push_back('{hi: 32'd1, lo: 32'd0});
`else
      sb.push_back('{hi: 32'd0, lo: 32'hFFFFFFFF});
`endif
      #1;
      acc_stall = bus.D_stall;
      tick();
      wait_done(bc, sc, to);
`ifdef MDU_MADD_EN
      n_checks++;
      if (to || bc !== 5 || acc_stall !== 1'b1)
         $display("FAIL madd_timing busy=%0d stall=%0b exp=5,1", bc, acc_stall);
      else n_pass++;
`else
      n_checks++;
      if (to || bc !== 0 || acc_stall !== 1'b0)
         $display("FAIL madd_ignored busy=%0d stall=%0b exp=0,0", bc, acc_stall);
      else n_pass++;
`endif
      e = sb.pop_front();
      n_checks++;
      if (bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL madd_result got=%h_%h exp=%h_%h", bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
`ifdef MDU_MADD_EN
      issue(4'd8, 32'd3, 32'd2);
      sb.push_back('{hi: 32'd0, lo: 32'hFFFFFFFA});
      tick();
      wait_done(bc, sc, to);
      e = sb.pop_front();
      n_checks++;
      if (to || bc !== 5 || bus.HI !== e.hi || bus.LO !== e.lo)
         $display("FAIL msub_result busy=%0d got=%h_%h exp=5 %h_%h", bc, bus.HI, bus.LO, e.hi, e.lo);
      else n_pass++;
`endif
      // undefined op code is ignored and never stalls
      issue(4'd9, 32'd7, 32'd7);
      #1;
      n_checks++;
      if (bus.D_stall !== 1'b0) $display("FAIL undef_stall got=%0b exp=0", bus.D_stall);
      else n_pass++;
      tick();
      idle_inputs();
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL undef_busy got=%0b exp=0", bus.busy);
      else n_pass++;
      bus.D_md_use = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      bus.E_abort  = 1'b0;
      bus.E_rd_hi  = 1'b0;
      bus.D_md_use = 1'b0;
      idle_inputs();
      #2;
      test_reset();
      #2;
      reset = 1'b1;
      tick();
      test_mult();
      test_multu();
      test_back_to_back();
      test_div_zero();
      test_abort();
      test_reset_mid_run();
      test_madd();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
